fc_data_xbar_rr: RTL and testbench



---
 rtl/fc_data_xbar_rr.sv | 99 +++++++++
 tb/tb_fc_data_xbar_rr.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fc_data_xbar_rr.sv
// fc_data_xbar_rr: N-master to 1-slave data crossbar with round-robin arbitration, stall lock and in-order response routing
module fc_data_xbar_rr #(
  parameter int N_MASTERS       = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int BE_WIDTH       = DATA_WIDTH / 8,
  localparam int IW             = $clog2(N_MASTERS),
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1),
  localparam int PW             = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_MASTERS-1:0]             m_req_i,
  output logic [N_MASTERS-1:0]             m_gnt_o,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr_i,
  input  logic [N_MASTERS-1:0]             m_we_i,
  input  logic [N_MASTERS*BE_WIDTH-1:0]    m_be_i,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_wdata_i,
  output logic [N_MASTERS-1:0]             m_rvalid_o,
  output logic [N_MASTERS*DATA_WIDTH-1:0]  m_rdata_o,
  output logic                             s_req_o,
  input  logic                             s_gnt_i,
  output logic [ADDR_WIDTH-1:0]            s_addr_o,
  output logic                             s_we_o,
  output logic [BE_WIDTH-1:0]              s_be_o,
  output logic [DATA_WIDTH-1:0]            s_wdata_o,
  input  logic                             s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]            s_rdata_i,
  output logic [CW-1:0]                    outstanding_o,
  output logic                             err_o
);
  localparam logic [N_MASTERS-1:0] ONE = {{(N_MASTERS-1){1'b0}}, 1'b1};
  logic [IW-1:0] ptr_q, ptr_d, lock_idx_q, rr_idx, winner, head;
  logic          lock_q, lock_hold, lock_drop, err_q, err_d, full, push, pop;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
  // first requesting master at or after the round-robin pointer, wrapping
  always_comb begin
    rr_idx = ptr_q;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (m_req_i[IW'((int'(ptr_q) + i) % N_MASTERS)]) rr_idx = IW'((int'(ptr_q) + i) % N_MASTERS);
    end
  end
  assign lock_hold = lock_q && m_req_i[lock_idx_q];
  assign lock_drop = lock_q && !m_req_i[lock_idx_q];
  assign winner    = lock_hold ? lock_idx_q : rr_idx;
  assign full      = count_q == CW'(MAX_OUTSTANDING);
  assign s_req_o   = |m_req_i && !full;
  assign push      = s_req_o && s_gnt_i;
  assign pop       = s_rvalid_i && count_q != '0;
  assign head      = fifo_q[rd_q];
  assign s_addr_o  = m_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_we_o    = m_we_i[winner];
  assign s_be_o    = m_be_i[winner*BE_WIDTH +: BE_WIDTH];
  assign s_wdata_o = m_wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
  assign m_gnt_o    = push ? ONE << winner : '0;
  assign m_rvalid_o = pop ? ONE << head : '0;
  assign outstanding_o = count_q;
  assign err_o         = err_q;
  // route response data only to the master at the FIFO head
  always_comb begin
    m_rdata_o = '0;
    for (int k = 0; k < N_MASTERS; k++) m_rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = (pop && head == IW'(k)) ? s_rdata_i : '0;
  end
  // next-state for pointer, FIFO indices, count and sticky error
  always_comb begin
    ptr_d   = push ? ((winner == IW'(N_MASTERS - 1)) ? '0 : winner + 1'b1) : ptr_q;
    wr_d    = push ? ((wr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d    = pop ? ((rd_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_q + 1'b1) : rd_q;
    count_d = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
    err_d   = err_q || (s_rvalid_i && count_q == '0) || lock_drop;
  end
  // control state; a stalled winner is locked until the slave accepts it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= s_req_o && !s_gnt_i;
      lock_idx_q <= winner;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end
  // response-routing storage; validity is tracked by the count, so no reset
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_q] <= winner;
  end
endmodule

// File: tb/tb_fc_data_xbar_rr.sv
// tb_fc_data_xbar_rr: directed checks of arbitration, lock, FIFO routing, full and reset behaviour
module tb_fc_data_xbar_rr;
  logic         clk = 0;
  logic         rst;
  logic [3:0]   m_req, m_gnt, m_we, m_rvalid;
  logic [127:0] m_addr, m_wdata, m_rdata;
  logic [15:0]  m_be;
  logic         s_req, s_gnt, s_we, s_rvalid, err;
  logic [31:0]  s_addr, s_wdata, s_rdata;
  logic [3:0]   s_be;
  logic [2:0]   outstanding;
  int           n_chk = 0, n_err = 0;
  logic [127:0] e;

  fc_data_xbar_rr #(.N_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk), .rst_i(rst), .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
    .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata), .s_req_o(s_req),
    .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata),
    .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .outstanding_o(outstanding), .err_o(err));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; m_req = 0; s_gnt = 0; s_rvalid = 0; s_rdata = 0; m_we = 0; m_be = '1;
    for (int k = 0; k < 4; k++) begin
      m_addr[k*32 +: 32]  = 32'h100 * (k + 1);
      m_wdata[k*32 +: 32] = 32'hD0 + k;
    end
    step(); step();
    rst = 0; #1;
    check("rst_sreq", s_req, 0);
    check("rst_gnt", m_gnt, 0);
    check("rst_rv", m_rvalid, 0);
    check("rst_out", outstanding, 0);
    check("rst_err", err, 0);
    step();
    // alternating grants between m0 and m1, each response to its issuer
    m_req = 4'b0011; s_gnt = 1;
    for (int i = 0; i < 4; i++) begin
      s_rvalid = i > 0; s_rdata = 32'h10 + i; #1;
      check("alt_gnt", m_gnt, 4'b1 << (i % 2));
      check("alt_addr", s_addr, 32'h100 * (i % 2 + 1));
      check("alt_rv", m_rvalid, i == 0 ? 4'b0 : 4'b1 << ((i - 1) % 2));
      e = i == 0 ? 128'h0 : {96'h0, 32'h10 + i} << (32 * ((i - 1) % 2));
      check("alt_rdata", m_rdata, e);
      check("alt_out", outstanding, i == 0 ? 0 : 1);
      step();
    end
    m_req = 0; s_rvalid = 1; s_rdata = 32'h55; #1;
    check("alt_drain_rv", m_rvalid, 4'b0010);
    step();
    s_rvalid = 0; #1;
    check("alt_out_end", outstanding, 0);
    // pointer is 2; masters 1 and 3 -> m3, m1, m3
    m_req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rr_gnt", m_gnt, i == 1 ? 4'b0010 : 4'b1000);
      step();
    end
    m_req = 0; s_rvalid = 1;
    for (int i = 0; i < 3; i++) begin
      s_rdata = 32'hA0 + i; #1;
      check("rr_rv", m_rvalid, i == 1 ? 4'b0010 : 4'b1000);
      e = {96'h0, 32'hA0 + i} << (i == 1 ? 32 : 96);
      check("rr_rdata", m_rdata, e);
      step();
    end
    s_rvalid = 0; #1;
    check("rr_out", outstanding, 0);
    // pointer is 0; m0 stalls 3 cycles while m1 joins
    m_req = 4'b0001; s_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_sreq", s_req, 1);
      check("stall_addr", s_addr, 32'h100);
      check("stall_gnt", m_gnt, 0);
      step();
      m_req = 4'b0011;
    end
    s_gnt = 1; #1;
    check("stall_gnt_m0", m_gnt, 4'b0001);
    check("stall_addr_m0", s_addr, 32'h100);
    step();
    m_req = 4'b0010; #1;
    check("stall_gnt_m1", m_gnt, 4'b0010);
    check("stall_addr_m1", s_addr, 32'h200);
    step();
    m_req = 0; s_rvalid = 1; #1;
    check("stall_rv0", m_rvalid, 4'b0001);
    step(); #1;
    check("stall_rv1", m_rvalid, 4'b0010);
    step();
    s_rvalid = 0;
    // fill to MAX_OUTSTANDING, then full blocks grants even during a pop
    m_req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fill_gnt", m_gnt, 4'b0001);
      step();
    end
    #1;
    check("full_sreq", s_req, 0);
    check("full_gnt", m_gnt, 0);
    check("full_out", outstanding, 4);
    s_rvalid = 1; #1;
    check("full_pop_gnt", m_gnt, 0);
    check("full_pop_rv", m_rvalid, 4'b0001);
    step();
    s_rvalid = 0; #1;
    check("full_out3", outstanding, 3);
    check("resume_gnt", m_gnt, 4'b0001);
    step();
    m_req = 0; s_rvalid = 1;
    for (int i = 0; i < 4; i++) step();
    s_rvalid = 0; #1;
    check("full_drain_out", outstanding, 0);
    // interleaved m2, m0, m2 with data A, B, C
    for (int i = 0; i < 3; i++) begin
      m_req = i == 1 ? 4'b0001 : 4'b0100; #1;
      check("il_gnt", m_gnt, m_req);
      step();
    end
    m_req = 0; s_rvalid = 1;
    for (int i = 0; i < 3; i++) begin
      s_rdata = 32'hA + i; #1;
      check("il_rv", m_rvalid, i == 1 ? 4'b0001 : 4'b0100);
      e = {96'h0, 32'hA + i} << (i == 1 ? 0 : 64);
      check("il_rdata", m_rdata, e);
      step();
    end
    s_rvalid = 0; #1;
    check("pre_rst_err", err, 0);
    // reset with 2 outstanding, then a stale response flags an error
    m_req = 4'b0001;
    step(); step();
    m_req = 0; #1;
    check("two_out", outstanding, 2);
    rst = 1; step();
    rst = 0; #1;
    check("mid_rst_out", outstanding, 0);
    check("mid_rst_err", err, 0);
    s_rvalid = 1; #1;
    check("stale_rv", m_rvalid, 0);
    step();
    s_rvalid = 0; #1;
    check("stale_err", err, 1);
    check("stale_out", outstanding, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
